// File: rtl/seq_mag_compare.sv
// Purpose : sequential magnitude comparator, SLICE bits per clock from the LSB slice up, with a 74HC85-style cascade input.
// Latency : done and result appear NSLICE = WIDTH/SLICE cycles after the edge that accepts start.
// Backpr. : start is ignored while busy. A start in the DONE cycle is accepted back-to-back. result holds until the next DONE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a comparison (accepted in IDLE or DONE)
//   a, b                operands, latched on accept
//   signed_mode         1 = two's-complement, 0 = unsigned, latched on accept
//   casc_in             {gt,eq,lt} from a lower-order stage, seeds the running value
//   busy                high while slices are being processed
//   done                one-cycle pulse when result is final
//   result              {gt,eq,lt}, one-hot once valid
module seq_mag_compare #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic [2:0]       casc_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic [2:0]       run_q, run_d;
  logic [2:0]       result_q, result_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [2:0]       slice_val;
  logic [2:0]       final_val;
  logic [2:0]       seed;
  logic             last;

  always_comb begin
    // Slice select by index
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end

    // A higher slice that differs overrides everything below it.
    // An equal slice passes the lower-order verdict through.
    if (a_sl > b_sl)      slice_val = R_GT;
    else if (a_sl < b_sl) slice_val = R_LT;
    else                  slice_val = run_q;

    // In signed mode, differing sign bits decide the result on their own:
    // the operand with the sign bit set is the smaller one.
    final_val = slice_val;
    if (sm_q && (a_q[WIDTH-1] != b_q[WIDTH-1]))
      final_val = a_q[WIDTH-1] ? R_LT : R_GT;

    // A cascade input that is not one-hot carries no verdict, so it seeds "equal".
    if ((casc_in == R_GT) || (casc_in == R_EQ) || (casc_in == R_LT)) seed = casc_in;
    else                                                              seed = R_EQ;

    last = (idx_q == IW'(NSLICE - 1));

    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sm_d     = sm_q;
    run_d    = run_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          run_d   = seed;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        run_d = slice_val;
        if (last) begin
          result_d = final_val;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      run_q    <= 3'b000;
      result_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sm_q     <= sm_d;
      run_q    <= run_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
